// File: rtl/nasti_sync_frontend_if.sv
// NASTI (AXI4-style) bus bundle; the slave modport is the view taken by a frontend.
interface nasti_if #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic [ID_W-1:0]     ar_id;
   logic [ADDR_W-1:0]   ar_addr;
   logic [7:0]          ar_len;
   logic [2:0]          ar_size;
   logic [1:0]          ar_burst;
   logic                ar_valid;
   logic                ar_ready;

   logic [ID_W-1:0]     aw_id;
   logic [ADDR_W-1:0]   aw_addr;
   logic [7:0]          aw_len;
   logic [2:0]          aw_size;
   logic [1:0]          aw_burst;
   logic                aw_valid;
   logic                aw_ready;

   logic [DATA_W-1:0]   w_data;
   logic [DATA_W/8-1:0] w_strb;
   logic                w_last;
   logic                w_valid;
   logic                w_ready;

   logic [ID_W-1:0]     r_id;
   logic [DATA_W-1:0]   r_data;
   logic [1:0]          r_resp;
   logic                r_last;
   logic                r_valid;
   logic                r_ready;

   logic [ID_W-1:0]     b_id;
   logic [1:0]          b_resp;
   logic                b_valid;
   logic                b_ready;

   modport slave (
      input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
      output ar_ready,
      input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
      output aw_ready,
      input  w_data, w_strb, w_last, w_valid,
      output w_ready,
      output r_id, r_data, r_resp, r_last, r_valid,
      input  r_ready,
      output b_id, b_resp, b_valid,
      input  b_ready
   );
endinterface

// File: rtl/nasti_sync_frontend.sv
// Single-clock NASTI slave frontend: five FWFT FIFOs, r_last generation from the
// accepted ar_len, optional AW-before-W ordering and outstanding-read tracking.

// Synchronous FWFT FIFO with 2**DEPTH entries; the extra pointer MSB separates full from empty.
module nasti_sync_fifo #(
   parameter int DEPTH = 3,
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             empty_o,
   output logic             full_o
);
   localparam logic [DEPTH:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem_q [2**DEPTH];
   logic [DEPTH:0]   wr_ptr_q, rd_ptr_q;

   // Pointer advance; pushes into a full FIFO and pops from an empty one are ignored.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_i && !full_o)  wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop_i  && !empty_o) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   // Storage write; contents need no reset because the pointers mark them invalid.
   always_ff @(posedge clk_i) begin
      if (push_i && !full_o) mem_q[wr_ptr_q[DEPTH-1:0]] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q[DEPTH-1:0]];
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[DEPTH] != rd_ptr_q[DEPTH]) &&
                    (wr_ptr_q[DEPTH-1:0] == rd_ptr_q[DEPTH-1:0]);
endmodule

module nasti_sync_frontend #(
   parameter int C_AR_DEPTH   = 3,
   parameter int C_AW_DEPTH   = 3,
   parameter int C_W_DEPTH    = 4,
   parameter int C_R_DEPTH    = 4,
   parameter int C_B_DEPTH    = 3,
   parameter int C_RD_OUTST   = 3,
   parameter int C_W_AFTER_AW = 1,
   parameter int C_AR_WIDTH   = 1,
   parameter int C_AW_WIDTH   = 1,
   parameter int C_W_WIDTH    = 1,
   parameter int C_R_WIDTH    = 1,
   parameter int C_B_WIDTH    = 1
) (
   input  logic                  core_clk,
   input  logic                  core_arstn,
   nasti_if.slave                s_nasti,
   output logic [C_AR_WIDTH-1:0] ar_data_o,
   output logic                  ar_valid_o,
   input  logic                  ar_ready_i,
   output logic [C_AW_WIDTH-1:0] aw_data_o,
   output logic                  aw_valid_o,
   input  logic                  aw_ready_i,
   output logic [C_W_WIDTH-1:0]  w_data_o,
   output logic                  w_valid_o,
   input  logic                  w_ready_i,
   input  logic [C_R_WIDTH-1:0]  r_data_i,
   input  logic                  r_valid_i,
   output logic                  r_ready_o,
   input  logic [C_B_WIDTH-1:0]  b_data_i,
   input  logic                  b_valid_i,
   output logic                  b_ready_o,
   output logic [C_RD_OUTST:0]   rd_outst_o
);
   localparam int LEN_W = $bits(s_nasti.ar_len);
   localparam int R_FW  = $bits(s_nasti.r_id) + $bits(s_nasti.r_data) + $bits(s_nasti.r_resp);
   localparam int B_FW  = $bits(s_nasti.b_id) + $bits(s_nasti.b_resp);
   localparam logic [8:0]          BEAT_ONE   = 1;
   localparam logic [C_RD_OUTST:0] OUTST_ONE  = 1;
   localparam logic [C_AW_DEPTH:0] CREDIT_ONE = 1;
   localparam logic [C_AW_DEPTH:0] CREDIT_MAX = '1;

   logic ar_full, ar_empty, len_full, len_empty, len_pop;
   logic aw_full, aw_empty, w_full, w_empty;
   logic r_full, r_empty, b_full, b_empty;
   logic ar_hs, aw_hs, w_hs, r_hs, b_hs, r_last_int;
   logic [LEN_W-1:0]     len_head;
   logic [C_R_WIDTH-1:0] r_head;
   logic [C_B_WIDTH-1:0] b_head;
   logic [R_FW-1:0]      r_fields;
   logic [B_FW-1:0]      b_fields;
   logic [8:0]           beat_cnt_q, beat_cnt_d;
   logic [C_RD_OUTST:0]  outst_q, outst_d;

   assign ar_hs = s_nasti.ar_valid && s_nasti.ar_ready;
   assign aw_hs = s_nasti.aw_valid && s_nasti.aw_ready;
   assign w_hs  = s_nasti.w_valid  && s_nasti.w_ready;
   assign r_hs  = s_nasti.r_valid  && s_nasti.r_ready;
   assign b_hs  = s_nasti.b_valid  && s_nasti.b_ready;

   // AR: address word to the core, burst length to the tracker that drives r_last.
   assign s_nasti.ar_ready = ~ar_full & ~len_full;
   assign ar_valid_o       = ~ar_empty;

   nasti_sync_fifo #(.DEPTH(C_AR_DEPTH), .WIDTH(C_AR_WIDTH)) u_ar_fifo (
      .clk_i(core_clk), .rst_ni(core_arstn), .push_i(ar_hs),
      .data_i(C_AR_WIDTH'({s_nasti.ar_id, s_nasti.ar_addr, s_nasti.ar_len,
                           s_nasti.ar_size, s_nasti.ar_burst})),
      .pop_i(ar_ready_i), .data_o(ar_data_o), .empty_o(ar_empty), .full_o(ar_full));

   nasti_sync_fifo #(.DEPTH(C_RD_OUTST), .WIDTH(LEN_W)) u_len_fifo (
      .clk_i(core_clk), .rst_ni(core_arstn), .push_i(ar_hs), .data_i(s_nasti.ar_len),
      .pop_i(len_pop), .data_o(len_head), .empty_o(len_empty), .full_o(len_full));

   // AW / W: words toward the core.
   assign aw_valid_o = ~aw_empty;
   assign w_valid_o  = ~w_empty;

   nasti_sync_fifo #(.DEPTH(C_AW_DEPTH), .WIDTH(C_AW_WIDTH)) u_aw_fifo (
      .clk_i(core_clk), .rst_ni(core_arstn), .push_i(aw_hs),
      .data_i(C_AW_WIDTH'({s_nasti.aw_id, s_nasti.aw_addr, s_nasti.aw_len,
                           s_nasti.aw_size, s_nasti.aw_burst})),
      .pop_i(aw_ready_i), .data_o(aw_data_o), .empty_o(aw_empty), .full_o(aw_full));

   nasti_sync_fifo #(.DEPTH(C_W_DEPTH), .WIDTH(C_W_WIDTH)) u_w_fifo (
      .clk_i(core_clk), .rst_ni(core_arstn), .push_i(w_hs),
      .data_i(C_W_WIDTH'({s_nasti.w_data, s_nasti.w_strb, s_nasti.w_last})),
      .pop_i(w_ready_i), .data_o(w_data_o), .empty_o(w_empty), .full_o(w_full));

   generate
      if (C_W_AFTER_AW != 0) begin : g_w_after_aw
         logic [C_AW_DEPTH:0] credit_q, credit_d;
         logic                w_last_hs;

         assign w_last_hs        = w_hs && s_nasti.w_last;
         assign s_nasti.w_ready  = ~w_full & (credit_q != '0);
         assign s_nasti.aw_ready = ~aw_full & (credit_q != CREDIT_MAX);

         // Credit register: one credit per accepted AW not yet closed by its last W beat.
         always_ff @(posedge core_clk or negedge core_arstn) begin
            if (!core_arstn) credit_q <= '0;
            else             credit_q <= credit_d;
         end

         // Credit next-state: AW adds, W-last removes, both together cancel.
         always_comb begin
            credit_d = credit_q;
            if (aw_hs && !w_last_hs)      credit_d = credit_q + CREDIT_ONE;
            else if (!aw_hs && w_last_hs) credit_d = credit_q - CREDIT_ONE;
         end
      end else begin : g_w_free
         assign s_nasti.w_ready  = ~w_full;
         assign s_nasti.aw_ready = ~aw_full;
      end
   endgenerate

   // R: beats only leave once a burst length is known, so r_last can be computed.
   assign r_ready_o       = ~r_full;
   assign s_nasti.r_valid = ~r_empty & ~len_empty;
   assign r_fields        = R_FW'(r_head);
   assign {s_nasti.r_id, s_nasti.r_data, s_nasti.r_resp} = r_fields;
   assign r_last_int      = (beat_cnt_q == 9'(len_head));
   assign s_nasti.r_last  = r_last_int;
   assign len_pop         = r_hs & r_last_int;

   nasti_sync_fifo #(.DEPTH(C_R_DEPTH), .WIDTH(C_R_WIDTH)) u_r_fifo (
      .clk_i(core_clk), .rst_ni(core_arstn), .push_i(r_valid_i), .data_i(r_data_i),
      .pop_i(r_hs), .data_o(r_head), .empty_o(r_empty), .full_o(r_full));

   // Beat counter and outstanding-burst count registers.
   always_ff @(posedge core_clk or negedge core_arstn) begin
      if (!core_arstn) begin
         beat_cnt_q <= '0;
         outst_q    <= '0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         outst_q    <= outst_d;
      end
   end

   // Beat counter restarts after the last beat; outstanding count mirrors tracker occupancy.
   always_comb begin
      beat_cnt_d = beat_cnt_q;
      outst_d    = outst_q;
      if (r_hs) beat_cnt_d = r_last_int ? '0 : beat_cnt_q + BEAT_ONE;
      if (ar_hs && !len_pop)      outst_d = outst_q + OUTST_ONE;
      else if (!ar_hs && len_pop) outst_d = outst_q - OUTST_ONE;
   end

   assign rd_outst_o = outst_q;

   // B: write responses toward the NASTI master.
   assign b_ready_o       = ~b_full;
   assign s_nasti.b_valid = ~b_empty;
   assign b_fields        = B_FW'(b_head);
   assign {s_nasti.b_id, s_nasti.b_resp} = b_fields;

   nasti_sync_fifo #(.DEPTH(C_B_DEPTH), .WIDTH(C_B_WIDTH)) u_b_fifo (
      .clk_i(core_clk), .rst_ni(core_arstn), .push_i(b_valid_i), .data_i(b_data_i),
      .pop_i(b_hs), .data_o(b_head), .empty_o(b_empty), .full_o(b_full));
endmodule
